// File: rtl/lsrs_pkg.sv
// -----------------------------------------------------------------------------
// lsrs_pkg
// Constants shared by the load/store reservation station and its neighbours.
//   ROB_SIZE_BIT  : width of a reorder-buffer tag
//   LSRS_SIZE_BIT : log2 of the number of reservation-station entries
//   OP_LOAD/OP_STORE : encoding of the single op bit carried with each entry
// -----------------------------------------------------------------------------
package lsrs_pkg;

    localparam int ROB_SIZE_BIT  = 4;
    localparam int LSRS_SIZE_BIT = 3;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;   // store or jalr

endpackage

// File: rtl/lsrs_if.sv
// -----------------------------------------------------------------------------
// lsrs_if
// Bundle of the dispatch, CDB and address-ALU issue signals of the reservation
// station.
//   master : dispatch unit / CDB / ALU side (drives disp_* and cdb_*)
//   slave  : the reservation station (drives full and alu_*)
// -----------------------------------------------------------------------------
interface lsrs_if
    import lsrs_pkg::*;
#(
    parameter int ROB_W = lsrs_pkg::ROB_SIZE_BIT
);
    // dispatch
    logic             disp_valid;
    logic             disp_op;
    logic [11:0]      disp_imm;
    logic [31:0]      disp_vj;
    logic [ROB_W-1:0] disp_qj;
    logic             disp_qj_busy;
    logic [ROB_W-1:0] disp_rob_entry;
    logic             full;
    // common data bus
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob_entry;
    logic [31:0]      cdb_value;
    // issue to the address ALU
    logic             alu_new;
    logic [31:0]      alu_vi;
    logic [11:0]      alu_imm;
    logic             alu_op;
    logic [ROB_W-1:0] alu_rob_entry;

    modport master (
        output disp_valid, disp_op, disp_imm, disp_vj, disp_qj, disp_qj_busy,
               disp_rob_entry, cdb_valid, cdb_rob_entry, cdb_value,
        input  full, alu_new, alu_vi, alu_imm, alu_op, alu_rob_entry
    );

    modport slave (
        input  disp_valid, disp_op, disp_imm, disp_vj, disp_qj, disp_qj_busy,
               disp_rob_entry, cdb_valid, cdb_rob_entry, cdb_value,
        output full, alu_new, alu_vi, alu_imm, alu_op, alu_rob_entry
    );

endinterface

// File: rtl/lsrs_pick.sv
// -----------------------------------------------------------------------------
// lsrs_pick
// Lowest-index find-first-set encoder.
//   req   : request vector, bit 0 has highest priority
//   found : any request bit set
//   idx   : index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module lsrs_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // scan downwards so the lowest set bit is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/lsrs.sv
// -----------------------------------------------------------------------------
// lsrs
// Load/store reservation station. Holds dispatched memory ops until their base
// register value is available, snoops the CDB for it, and issues one ready
// entry per cycle (lowest index first) to the address ALU.
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-high reset
//   rdy_in   : global pause, low freezes all state
//   clear_in : misprediction flush, empties the station
//   bus      : dispatch / CDB / ALU issue signals (lsrs_if.slave)
// -----------------------------------------------------------------------------
module lsrs
    import lsrs_pkg::*;
#(
    parameter int LSRS_SIZE_BIT = lsrs_pkg::LSRS_SIZE_BIT,
    parameter int ROB_SIZE_BIT  = lsrs_pkg::ROB_SIZE_BIT
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    input  logic  clear_in,
    lsrs_if.slave bus
);

    localparam int N = 1 << LSRS_SIZE_BIT;

    // entry storage
    logic [N-1:0]            busy_q, busy_d;
    logic [N-1:0]            qj_busy_q, qj_busy_d;
    logic [N-1:0]            op_q, op_d;
    logic [11:0]             imm_q [N];
    logic [11:0]             imm_d [N];
    logic [31:0]             vj_q  [N];
    logic [31:0]             vj_d  [N];
    logic [ROB_SIZE_BIT-1:0] qj_q  [N];
    logic [ROB_SIZE_BIT-1:0] qj_d  [N];
    logic [ROB_SIZE_BIT-1:0] rob_q [N];
    logic [ROB_SIZE_BIT-1:0] rob_d [N];

    // issue registers
    logic                    alu_new_q, alu_new_d;
    logic [31:0]             alu_vi_q, alu_vi_d;
    logic [11:0]             alu_imm_q, alu_imm_d;
    logic                    alu_op_q, alu_op_d;
    logic [ROB_SIZE_BIT-1:0] alu_rob_q, alu_rob_d;

    logic [N-1:0]             free_vec, ready_vec;
    logic                     free_found, ready_found;
    logic [LSRS_SIZE_BIT-1:0] free_idx, ready_idx;
    logic                     full;

    // Ready is taken from registered state only, so a CDB wake-up or a
    // dispatch at this edge can issue no earlier than the next edge.
    for (genvar gi = 0; gi < N; gi++) begin : g_vec
        assign free_vec[gi]  = ~busy_q[gi];
        assign ready_vec[gi] = busy_q[gi] & ~qj_busy_q[gi];
    end

    lsrs_pick #(.N(N), .W(LSRS_SIZE_BIT)) u_pick_free (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    lsrs_pick #(.N(N), .W(LSRS_SIZE_BIT)) u_pick_ready (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    // Full looks at start-of-cycle occupancy; a slot freed by this cycle's
    // issue is not offered to dispatch until the next cycle.
    assign full     = &busy_q;
    assign bus.full = full;

    always_comb begin
        busy_d    = busy_q;
        qj_busy_d = qj_busy_q;
        op_d      = op_q;
        imm_d     = imm_q;
        vj_d      = vj_q;
        qj_d      = qj_q;
        rob_d     = rob_q;
        alu_new_d = alu_new_q;
        alu_vi_d  = alu_vi_q;
        alu_imm_d = alu_imm_q;
        alu_op_d  = alu_op_q;
        alu_rob_d = alu_rob_q;

        if (clear_in) begin
            busy_d    = '0;
            alu_new_d = 1'b0;
        end else if (rdy_in) begin
            // CDB snoop on waiting entries
            if (bus.cdb_valid) begin
                for (int i = 0; i < N; i++) begin
                    if (busy_q[i] && qj_busy_q[i] && qj_q[i] == bus.cdb_rob_entry) begin
                        vj_d[i]      = bus.cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end
                end
            end

            // issue
            if (ready_found) begin
                alu_new_d         = 1'b1;
                alu_vi_d          = vj_q[ready_idx];
                alu_imm_d         = imm_q[ready_idx];
                alu_op_d          = op_q[ready_idx];
                alu_rob_d         = rob_q[ready_idx];
                busy_d[ready_idx] = 1'b0;
            end else begin
                alu_new_d = 1'b0;
            end

            // dispatch; the chosen slot is free so it never collides with issue
            if (bus.disp_valid && !full && free_found) begin
                busy_d[free_idx] = 1'b1;
                op_d[free_idx]   = bus.disp_op;
                imm_d[free_idx]  = bus.disp_imm;
                qj_d[free_idx]   = bus.disp_qj;
                rob_d[free_idx]  = bus.disp_rob_entry;
                // operand arriving on the CDB in the dispatch cycle itself
                if (bus.disp_qj_busy && bus.cdb_valid && bus.cdb_rob_entry == bus.disp_qj) begin
                    vj_d[free_idx]      = bus.cdb_value;
                    qj_busy_d[free_idx] = 1'b0;
                end else begin
                    vj_d[free_idx]      = bus.disp_vj;
                    qj_busy_d[free_idx] = bus.disp_qj_busy;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q    <= '0;
            qj_busy_q <= '0;
            op_q      <= '0;
            for (int i = 0; i < N; i++) begin
                imm_q[i] <= '0;
                vj_q[i]  <= '0;
                qj_q[i]  <= '0;
                rob_q[i] <= '0;
            end
            alu_new_q <= 1'b0;
            alu_vi_q  <= '0;
            alu_imm_q <= '0;
            alu_op_q  <= 1'b0;
            alu_rob_q <= '0;
        end else begin
            busy_q    <= busy_d;
            qj_busy_q <= qj_busy_d;
            op_q      <= op_d;
            imm_q     <= imm_d;
            vj_q      <= vj_d;
            qj_q      <= qj_d;
            rob_q     <= rob_d;
            alu_new_q <= alu_new_d;
            alu_vi_q  <= alu_vi_d;
            alu_imm_q <= alu_imm_d;
            alu_op_q  <= alu_op_d;
            alu_rob_q <= alu_rob_d;
        end
    end

    assign bus.alu_new       = alu_new_q;
    assign bus.alu_vi        = alu_vi_q;
    assign bus.alu_imm       = alu_imm_q;
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_rob_entry = alu_rob_q;

endmodule

// File: tb/tb_lsrs.sv
// -----------------------------------------------------------------------------
// tb_lsrs
// Directed stimulus for the load/store reservation station. Each expected issue
// (edge number and payload) is queued when its stimulus is applied; a monitor
// on the falling edge pops and compares whenever alu_new reports a new issue.
// -----------------------------------------------------------------------------
module tb_lsrs;
    import lsrs_pkg::*;

    typedef struct {
        int                      edge_no;
        logic [31:0]             vi;
        logic [11:0]             imm;
        logic                    op;
        logic [ROB_SIZE_BIT-1:0] rob;
    } exp_t;

    logic clk;
    logic rst;
    logic rdy;
    logic clear;

    lsrs_if #(.ROB_W(ROB_SIZE_BIT)) bus ();

    lsrs #(
        .LSRS_SIZE_BIT (LSRS_SIZE_BIT),
        .ROB_SIZE_BIT  (ROB_SIZE_BIT)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .rdy_in   (rdy),
        .clear_in (clear),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    logic rdy_prev = 1'b0;
    exp_t sb[$];

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rdy_prev <= rdy;
    end

    // monitor: a new issue is alu_new high after an edge where the station ran
    always @(negedge clk) begin
        if (!rst && rdy_prev && bus.alu_new) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: edge %0d got rob=%0d vi=%h, required no issue",
                         edge_cnt, bus.alu_rob_entry, bus.alu_vi);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.edge_no != edge_cnt || e.vi !== bus.alu_vi || e.imm !== bus.alu_imm ||
                    e.op !== bus.alu_op || e.rob !== bus.alu_rob_entry) begin
                    errors++;
                    $display("FAIL issue: got edge=%0d vi=%h imm=%h op=%b rob=%0d, required edge=%0d vi=%h imm=%h op=%b rob=%0d",
                             edge_cnt, bus.alu_vi, bus.alu_imm, bus.alu_op, bus.alu_rob_entry,
                             e.edge_no, e.vi, e.imm, e.op, e.rob);
                end else begin
                    $display("issue edge=%0d vi=%h imm=%h op=%b rob=%0d ok",
                             edge_cnt, bus.alu_vi, bus.alu_imm, bus.alu_op, bus.alu_rob_entry);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    task automatic push(input int ed, input logic [31:0] vi, input logic [11:0] imm,
                        input logic op, input logic [ROB_SIZE_BIT-1:0] rob);
        exp_t e;
        e.edge_no = ed;
        e.vi      = vi;
        e.imm     = imm;
        e.op      = op;
        e.rob     = rob;
        sb.push_back(e);
    endtask

    task automatic set_disp(input logic op, input logic [11:0] imm, input logic [31:0] vj,
                            input logic [ROB_SIZE_BIT-1:0] qj, input logic qjb,
                            input logic [ROB_SIZE_BIT-1:0] rob);
        bus.disp_valid     = 1'b1;
        bus.disp_op        = op;
        bus.disp_imm       = imm;
        bus.disp_vj        = vj;
        bus.disp_qj        = qj;
        bus.disp_qj_busy   = qjb;
        bus.disp_rob_entry = rob;
    endtask

    task automatic set_cdb(input logic [ROB_SIZE_BIT-1:0] tag, input logic [31:0] val);
        bus.cdb_valid     = 1'b1;
        bus.cdb_rob_entry = tag;
        bus.cdb_value     = val;
    endtask

    // advance one edge, then drop the single-cycle request strobes
    task automatic edge_go();
        @(posedge clk);
        #1;
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        clear          = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_alu_new"}, 32'(bus.alu_new), 32'h0);
        chk({tag, "_alu_vi"},  bus.alu_vi, 32'h0);
        chk({tag, "_alu_imm"}, 32'(bus.alu_imm), 32'h0);
        chk({tag, "_alu_op"},  32'(bus.alu_op), 32'h0);
        chk({tag, "_alu_rob"}, 32'(bus.alu_rob_entry), 32'h0);
        chk({tag, "_full"},    32'(bus.full), 32'h0);
    endtask

    int d;
    int w;

    initial begin
        rst   = 1'b1;
        rdy   = 1'b1;
        clear = 1'b0;
        bus.disp_valid     = 1'b0;
        bus.disp_op        = 1'b0;
        bus.disp_imm       = '0;
        bus.disp_vj        = '0;
        bus.disp_qj        = '0;
        bus.disp_qj_busy   = 1'b0;
        bus.disp_rob_entry = '0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_rob_entry  = '0;
        bus.cdb_value      = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b0;
        edge_go();

        // ready dispatch issues one edge after it is written
        d = edge_cnt + 1;
        set_disp(OP_LOAD, 12'h004, 32'h0000_1000, 4'd0, 1'b0, 4'd3);
        push(d + 1, 32'h0000_1000, 12'h004, OP_LOAD, 4'd3);
        edge_go();
        repeat (2) edge_go();

        // pending on tag 5, woken two cycles later
        d = edge_cnt + 1;
        set_disp(OP_STORE, 12'h7ff, 32'h0000_dead, 4'd5, 1'b1, 4'd6);
        edge_go();
        edge_go();
        set_cdb(4'd5, 32'h0000_2000);
        push(d + 3, 32'h0000_2000, 12'h7ff, OP_STORE, 4'd6);
        edge_go();
        chk("wake_not_yet_issued", 32'(bus.alu_new), 32'h0);
        repeat (2) edge_go();

        // fill all 8 slots with pending entries
        for (int i = 0; i < 8; i++) begin
            chk("full_while_filling", 32'(bus.full), 32'h0);
            set_disp(OP_LOAD, 12'(i), 32'(i), (i == 0) ? 4'd1 : 4'd9, 1'b1, 4'(i));
            edge_go();
        end
        chk("full_after_fill", 32'(bus.full), 32'h1);
        // dropped: would otherwise issue immediately as it is ready
        set_disp(OP_STORE, 12'h0ff, 32'h0000_0bad, 4'd0, 1'b0, 4'd15);
        edge_go();
        chk("full_after_drop", 32'(bus.full), 32'h1);
        w = edge_cnt + 1;
        set_cdb(4'd1, 32'h0000_5555);
        push(w + 1, 32'h0000_5555, 12'h000, OP_LOAD, 4'd0);
        edge_go();
        chk("full_after_wake", 32'(bus.full), 32'h1);
        edge_go();
        chk("full_after_issue", 32'(bus.full), 32'h0);
        set_disp(OP_STORE, 12'h123, 32'h0000_7777, 4'd0, 1'b0, 4'd8);
        push(w + 3, 32'h0000_7777, 12'h123, OP_STORE, 4'd8);
        edge_go();
        chk("full_after_refill", 32'(bus.full), 32'h1);
        edge_go();
        // wake the rest: issue order follows slot index 1..7
        w = edge_cnt + 1;
        set_cdb(4'd9, 32'h0000_9999);
        for (int k = 1; k < 8; k++) begin
            push(w + k, 32'h0000_9999, 12'(k), OP_LOAD, 4'(k));
        end
        edge_go();
        repeat (8) edge_go();
        chk("empty_after_drain", 32'(bus.full), 32'h0);

        // operand delivered on the CDB in the dispatch cycle
        d = edge_cnt + 1;
        set_disp(OP_LOAD, 12'h010, 32'h0, 4'd2, 1'b1, 4'd4);
        set_cdb(4'd2, 32'h0000_abcd);
        push(d + 1, 32'h0000_abcd, 12'h010, OP_LOAD, 4'd4);
        edge_go();
        repeat (2) edge_go();

        // flush after the first of three issues
        d = edge_cnt + 1;
        set_disp(OP_LOAD, 12'h001, 32'h0000_0111, 4'd0, 1'b0, 4'd1);
        push(d + 1, 32'h0000_0111, 12'h001, OP_LOAD, 4'd1);
        edge_go();
        set_disp(OP_LOAD, 12'h002, 32'h0000_0222, 4'd0, 1'b0, 4'd2);
        edge_go();
        set_disp(OP_LOAD, 12'h003, 32'h0000_0333, 4'd0, 1'b0, 4'd3);
        clear = 1'b1;
        edge_go();
        chk("clear_alu_new", 32'(bus.alu_new), 32'h0);
        chk("clear_full", 32'(bus.full), 32'h0);
        repeat (3) edge_go();

        // pause with ready entries
        set_disp(OP_LOAD, 12'h00a, 32'h0, 4'd7, 1'b1, 4'd10);
        edge_go();
        set_disp(OP_STORE, 12'h00b, 32'h0, 4'd7, 1'b1, 4'd11);
        edge_go();
        set_disp(OP_LOAD, 12'h00c, 32'h0, 4'd7, 1'b1, 4'd12);
        edge_go();
        w = edge_cnt + 1;
        set_cdb(4'd7, 32'h0000_7070);
        push(w + 1, 32'h0000_7070, 12'h00a, OP_LOAD, 4'd10);
        push(w + 5, 32'h0000_7070, 12'h00b, OP_STORE, 4'd11);
        push(w + 6, 32'h0000_7070, 12'h00c, OP_LOAD, 4'd12);
        edge_go();
        edge_go();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            // ignored while paused
            set_disp(OP_STORE, 12'h0ee, 32'h0000_eeee, 4'd0, 1'b0, 4'd13);
            edge_go();
            chk("freeze_alu_new", 32'(bus.alu_new), 32'h1);
            chk("freeze_alu_rob", 32'(bus.alu_rob_entry), 32'd10);
            chk("freeze_alu_vi", bus.alu_vi, 32'h0000_7070);
        end
        rdy = 1'b1;
        repeat (3) edge_go();

        // asynchronous reset with one issue done and another entry in flight
        d = edge_cnt + 1;
        set_disp(OP_STORE, 12'h055, 32'h0000_5050, 4'd0, 1'b0, 4'd13);
        push(d + 1, 32'h0000_5050, 12'h055, OP_STORE, 4'd13);
        edge_go();
        set_disp(OP_LOAD, 12'h066, 32'h0000_6060, 4'd0, 1'b0, 4'd14);
        edge_go();
        #6;
        rst = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) edge_go();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_issues: got %0d still expected, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
